// File: rtl/kmkz_rvc_expand_if.sv
// rtl/kmkz_rvc_expand_if.sv - fetch/decode handshake bundle for the RVC expansion stage
interface kmkz_rvc_expand_if;
    logic [31:0] ir_i;
    logic [31:0] pc_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] ir_o;
    logic [31:0] pc_o;
    logic        compressed_o;
    logic        illegal_o;
    logic        valid_o;
    logic        ready_i;
    logic        clear_i;

    modport master (
        output ir_i, pc_i, valid_i, ready_i, clear_i,
        input  ready_o, ir_o, pc_o, compressed_o, illegal_o, valid_o
    );

    modport slave (
        input  ir_i, pc_i, valid_i, ready_i, clear_i,
        output ready_o, ir_o, pc_o, compressed_o, illegal_o, valid_o
    );
endinterface

// File: rtl/kmkz_rvc_expand.sv
// rtl/kmkz_rvc_expand.sv - RV32C to RV32I expansion stage with a two-entry skid buffer
module kmkz_rvc_expand (
    input  logic                 clk_i,
    input  logic                 rst_i,
    kmkz_rvc_expand_if.slave     bus
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state_q, state_d;
    logic   load_main_in, load_main_skid, load_skid;

    logic [31:0] main_ir_q, main_pc_q, skid_ir_q, skid_pc_q;
    logic        main_c_q, main_ill_q, skid_c_q, skid_ill_q;

    logic [15:0] c;
    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [11:0] imm6_sx, a16sp_imm;
    logic [9:0]  addi4spn_imm;
    logic [6:0]  lw_off;
    logic [7:0]  lwsp_off, swsp_off;
    logic [20:0] j_off;
    logic [19:0] j_imm20, lui_imm;
    logic [12:0] b_off;
    logic [6:0]  b_hi;
    logic [4:0]  b_lo;
    logic [31:0] cir, exp_ir;
    logic        cill, exp_c;

    assign c            = bus.ir_i[15:0];
    assign rd           = c[11:7];
    assign rs2          = c[6:2];
    assign rdp          = {2'b01, c[4:2]};
    assign rs1p         = {2'b01, c[9:7]};
    assign imm6_sx      = {{6{c[12]}}, c[12], c[6:2]};
    assign addi4spn_imm = {c[10:7], c[12:11], c[5], c[6], 2'b00};
    assign lw_off       = {c[5], c[12:10], c[6], 2'b00};
    assign lwsp_off     = {c[3:2], c[12], c[6:4], 2'b00};
    assign swsp_off     = {c[8:7], c[12:9], 2'b00};
    assign a16sp_imm    = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000};
    assign lui_imm      = {{14{c[12]}}, c[12], c[6:2]};
    assign j_off        = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
    assign j_imm20      = {j_off[20], j_off[10:1], j_off[11], j_off[19:12]};
    assign b_off        = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3], 1'b0};
    assign b_hi         = {b_off[12], b_off[10:5]};
    assign b_lo         = {b_off[4:1], b_off[11]};

    // Shift amounts with bit 5 set have no RV32 meaning, so they are flagged illegal.
    always_comb begin
        cir  = '0;
        cill = 1'b0;
        case (c[1:0])
            2'b00: case (c[15:13])
                3'b000: if (addi4spn_imm == '0) cill = 1'b1;
                        else cir = {2'b00, addi4spn_imm, 5'd2, 3'b000, rdp, 7'h13};
                3'b010: cir = {5'b0, lw_off, rs1p, 3'b010, rdp, 7'h03};
                3'b110: cir = {5'b0, lw_off[6:5], rdp, rs1p, 3'b010, lw_off[4:0], 7'h23};
                default: cill = 1'b1;
            endcase
            2'b01: case (c[15:13])
                3'b000: cir = {imm6_sx, rd, 3'b000, rd, 7'h13};
                3'b001: cir = {j_imm20, 5'd1, 7'h6F};
                3'b010: cir = {imm6_sx, 5'd0, 3'b000, rd, 7'h13};
                3'b011: begin
                    if (rd == 5'd2) begin
                        if (a16sp_imm == '0) cill = 1'b1;
                        else cir = {a16sp_imm, 5'd2, 3'b000, 5'd2, 7'h13};
                    end else if ({c[12], c[6:2]} == 6'd0) begin
                        cill = 1'b1;
                    end else begin
                        cir = {lui_imm, rd, 7'h37};
                    end
                end
                3'b100: case (c[11:10])
                    2'b00: if (c[12]) cill = 1'b1;
                           else cir = {7'b0000000, rs2, rs1p, 3'b101, rs1p, 7'h13};
                    2'b01: if (c[12]) cill = 1'b1;
                           else cir = {7'b0100000, rs2, rs1p, 3'b101, rs1p, 7'h13};
                    2'b10: cir = {imm6_sx, rs1p, 3'b111, rs1p, 7'h13};
                    default: if (c[12]) cill = 1'b1;
                        else case (c[6:5])
                            2'b00: cir = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'h33};
                            2'b01: cir = {7'b0000000, rdp, rs1p, 3'b100, rs1p, 7'h33};
                            2'b10: cir = {7'b0000000, rdp, rs1p, 3'b110, rs1p, 7'h33};
                            default: cir = {7'b0000000, rdp, rs1p, 3'b111, rs1p, 7'h33};
                        endcase
                endcase
                3'b101: cir = {j_imm20, 5'd0, 7'h6F};
                default: cir = {b_hi, 5'd0, rs1p, 2'b00, c[13], b_lo, 7'h63};
            endcase
            2'b10: case (c[15:13])
                3'b000: if (c[12]) cill = 1'b1;
                        else cir = {7'b0000000, rs2, rd, 3'b001, rd, 7'h13};
                3'b010: if (rd == 5'd0) cill = 1'b1;
                        else cir = {4'b0000, lwsp_off, 5'd2, 3'b010, rd, 7'h03};
                3'b100: begin
                    if (!c[12]) begin
                        if (rs2 != 5'd0)     cir = {7'b0, rs2, 5'd0, 3'b000, rd, 7'h33};
                        else if (rd == 5'd0) cill = 1'b1;
                        else                 cir = {12'b0, rd, 3'b000, 5'd0, 7'h67};
                    end else begin
                        if (rs2 != 5'd0)     cir = {7'b0, rs2, rd, 3'b000, rd, 7'h33};
                        else if (rd == 5'd0) cir = 32'h0010_0073;
                        else                 cir = {12'b0, rd, 3'b000, 5'd1, 7'h67};
                    end
                end
                3'b110: cir = {4'b0000, swsp_off[7:5], rs2, 5'd2, 3'b010, swsp_off[4:0], 7'h23};
                default: cill = 1'b1;
            endcase
            default: cir = bus.ir_i;
        endcase
        if (cill) cir = '0;
    end

    assign exp_c  = (c[1:0] != 2'b11);
    assign exp_ir = cir;

    // Slot valid bits are the state itself; ready_o comes straight off the state register.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (bus.clear_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (bus.valid_i) begin
                    state_d      = ONE;
                    load_main_in = 1'b1;
                end
                ONE: begin
                    if (bus.valid_i && bus.ready_i) begin
                        load_main_in = 1'b1;
                    end else if (bus.valid_i) begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end else if (bus.ready_i) begin
                        state_d = EMPTY;
                    end
                end
                TWO: if (bus.ready_i) begin
                    state_d        = ONE;
                    load_main_skid = 1'b1;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_ir_q  <= '0;
            main_pc_q  <= '0;
            main_c_q   <= 1'b0;
            main_ill_q <= 1'b0;
        end else if (load_main_in) begin
            main_ir_q  <= exp_ir;
            main_pc_q  <= bus.pc_i;
            main_c_q   <= exp_c;
            main_ill_q <= cill;
        end else if (load_main_skid) begin
            main_ir_q  <= skid_ir_q;
            main_pc_q  <= skid_pc_q;
            main_c_q   <= skid_c_q;
            main_ill_q <= skid_ill_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (load_skid) begin
            skid_ir_q  <= exp_ir;
            skid_pc_q  <= bus.pc_i;
            skid_c_q   <= exp_c;
            skid_ill_q <= cill;
        end
    end

    assign bus.ready_o      = (state_q != TWO);
    assign bus.valid_o      = (state_q != EMPTY);
    assign bus.ir_o         = main_ir_q;
    assign bus.pc_o         = main_pc_q;
    assign bus.compressed_o = main_c_q;
    assign bus.illegal_o    = main_ill_q;
endmodule

// File: tb/tb_kmkz_rvc_expand.sv
// tb/tb_kmkz_rvc_expand.sv - vector table and scoreboard bench for kmkz_rvc_expand
module tb_kmkz_rvc_expand;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kmkz_rvc_expand_if bus ();
    kmkz_rvc_expand dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    typedef struct {
        logic [31:0] ir;
        logic [31:0] exp_ir;
        logic        c;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        logic        c;
        logic        ill;
    } exp_t;

    vec_t vecs[20];
    exp_t sb[$];
    int total = 0;
    int bad = 0;
    logic [31:0] cur_ir;
    logic        cur_c, cur_ill;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.valid_o && bus.ready_i) begin
                if (sb.size() == 0) begin
                    check("unexpected_output_pc", bus.pc_o, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ir_o", bus.ir_o, e.ir);
                    check("pc_o", bus.pc_o, e.pc);
                    check("compressed_o", {31'b0, bus.compressed_o}, {31'b0, e.c});
                    check("illegal_o", {31'b0, bus.illegal_o}, {31'b0, e.ill});
                end
            end
            if (bus.clear_i) sb.delete();
            else if (bus.valid_i && bus.ready_o)
                sb.push_back('{ir: cur_ir, pc: bus.pc_i, c: cur_c, ill: cur_ill});
        end
    end

    task automatic send(input logic [31:0] ir, input logic [31:0] pc,
                        input logic [31:0] eir, input logic ec, input logic eill);
        bit ok = 1'b0;
        bus.ir_i = ir; bus.pc_i = pc; bus.valid_i = 1'b1;
        cur_ir = eir; cur_c = ec; cur_ill = eill;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.ready_o) begin ok = 1'b1; break; end
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'h0010_8093, 32'h0010_8093, 1'b0, 1'b0};
        vecs[1]  = '{32'h0000_0085, 32'h0010_8093, 1'b1, 1'b0};
        vecs[2]  = '{32'h0000_557D, 32'hFFF0_0513, 1'b1, 1'b0};
        vecs[3]  = '{32'h0000_8082, 32'h0000_8067, 1'b1, 1'b0};
        vecs[4]  = '{32'h0000_0001, 32'h0000_0013, 1'b1, 1'b0};
        vecs[5]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1};
        vecs[6]  = '{32'h0000_6000, 32'h0000_0000, 1'b1, 1'b1};
        vecs[7]  = '{32'h0000_852E, 32'h00B0_0533, 1'b1, 1'b0};
        vecs[8]  = '{32'h0000_4002, 32'h0000_0000, 1'b1, 1'b1};
        vecs[9]  = '{32'h0000_8002, 32'h0000_0000, 1'b1, 1'b1};
        vecs[10] = '{32'h0000_6101, 32'h0000_0000, 1'b1, 1'b1};
        vecs[11] = '{32'h0000_6081, 32'h0000_0000, 1'b1, 1'b1};
        vecs[12] = '{32'h0000_4001, 32'h0000_0013, 1'b1, 1'b0};
        vecs[13] = '{32'h0000_0004, 32'h0000_0000, 1'b1, 1'b1};
        vecs[14] = '{32'h0000_8C09, 32'h40A4_0433, 1'b1, 1'b0};
        vecs[15] = '{32'h0000_9C09, 32'h0000_0000, 1'b1, 1'b1};
        vecs[16] = '{32'h0000_A001, 32'h0000_006F, 1'b1, 1'b0};
        vecs[17] = '{32'h0000_C001, 32'h0004_0063, 1'b1, 1'b0};
        vecs[18] = '{32'hABCD_2000, 32'h0000_0000, 1'b1, 1'b1};
        vecs[19] = '{32'h0000_9002, 32'h0010_0073, 1'b1, 1'b0};

        bus.ir_i = '0; bus.pc_i = '0; bus.valid_i = 1'b0;
        bus.ready_i = 1'b0; bus.clear_i = 1'b0;
        cur_ir = '0; cur_c = 1'b0; cur_ill = 1'b0;
        idle(3);
        rst = 1'b0;
        #1;
        check("reset_valid_o", {31'b0, bus.valid_o}, 32'd0);
        check("reset_ready_o", {31'b0, bus.ready_o}, 32'd1);
        check("reset_ir_o", bus.ir_o, 32'd0);
        check("reset_pc_o", bus.pc_o, 32'd0);
        check("reset_compressed_o", {31'b0, bus.compressed_o}, 32'd0);
        check("reset_illegal_o", {31'b0, bus.illegal_o}, 32'd0);

        // Passthrough latency with decode ready.
        bus.ready_i = 1'b1;
        send(32'h0010_8093, 32'h100, 32'h0010_8093, 1'b0, 1'b0);
        check("latency_valid_o", {31'b0, bus.valid_o}, 32'd1);
        check("latency_pc_o", bus.pc_o, 32'h100);
        idle(2);

        for (int i = 0; i < 20; i++)
            send(vecs[i].ir, 32'h1000 + 32'(i * 4), vecs[i].exp_ir, vecs[i].c, vecs[i].ill);
        idle(3);
        check("table_drained", sb.size(), 32'd0);

        // Backpressure: two accepts fill the stage, then drain in order.
        bus.ready_i = 1'b0;
        send(32'h0000_0001, 32'd0, 32'h0000_0013, 1'b1, 1'b0);
        send(32'h0000_0085, 32'd4, 32'h0010_8093, 1'b1, 1'b0);
        check("bp_ready_o_low", {31'b0, bus.ready_o}, 32'd0);
        check("bp_held_pc", bus.pc_o, 32'd0);
        idle(2);
        check("bp_still_held_pc", bus.pc_o, 32'd0);
        bus.ready_i = 1'b1;
        send(32'h0010_8093, 32'd8, 32'h0010_8093, 1'b0, 1'b0);
        send(32'h0000_557D, 32'd12, 32'hFFF0_0513, 1'b1, 1'b0);
        idle(4);
        check("bp_drained", sb.size(), 32'd0);

        // Flush while full, with an input offered in the clear cycle.
        bus.ready_i = 1'b0;
        send(32'h0000_0001, 32'h30, 32'h0000_0013, 1'b1, 1'b0);
        send(32'h0000_0001, 32'h34, 32'h0000_0013, 1'b1, 1'b0);
        bus.clear_i = 1'b1; bus.valid_i = 1'b1; bus.pc_i = 32'h40; bus.ir_i = 32'h0010_8093;
        idle(1);
        bus.clear_i = 1'b0; bus.valid_i = 1'b0;
        check("flush_valid_o", {31'b0, bus.valid_o}, 32'd0);
        check("flush_ready_o", {31'b0, bus.ready_o}, 32'd1);
        bus.ready_i = 1'b1;
        idle(4);

        // Reset while full, then first transfer after reset.
        bus.ready_i = 1'b0;
        send(32'h0000_0085, 32'h50, 32'h0010_8093, 1'b1, 1'b0);
        send(32'h0000_0000, 32'h54, 32'h0000_0000, 1'b1, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("rst2_valid_o", {31'b0, bus.valid_o}, 32'd0);
        check("rst2_ready_o", {31'b0, bus.ready_o}, 32'd1);
        check("rst2_ir_o", bus.ir_o, 32'd0);
        check("rst2_pc_o", bus.pc_o, 32'd0);
        check("rst2_illegal_o", {31'b0, bus.illegal_o}, 32'd0);
        check("rst2_compressed_o", {31'b0, bus.compressed_o}, 32'd0);
        bus.ready_i = 1'b1;
        send(32'h0000_8082, 32'h200, 32'h0000_8067, 1'b1, 1'b0);
        check("rst2_latency_valid_o", {31'b0, bus.valid_o}, 32'd1);
        check("rst2_latency_pc_o", bus.pc_o, 32'h200);
        idle(3);
        check("final_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
